// File: rtl/clock_mode_controller.sv
// clock_mode_controller: front-panel mode sequencer for the alarm clock.
// Converts debounced button levels into single-cycle increment strobes for
// set_time_module, selects what display_module shows and which field blinks,
// and runs the alarm ringing / snooze state machine. Runs on Clk_sys.
module clock_mode_controller #(
  parameter int TIMEOUT_S  = 10,
  parameter int RING_S     = 60,
  parameter int SNOOZE_S   = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tick_1Hz,
  input  logic       Mode_btn,
  input  logic       Next_btn,
  input  logic       Inc_btn,
  input  logic       Snooze_btn,
  input  logic       Alarm_en,
  input  logic       Alarm_match,
  output logic [2:0] Mode,
  output logic [1:0] Field,
  output logic       Inc_D,
  output logic       Inc_H,
  output logic       Inc_M,
  output logic       Tgt_alarm,
  output logic       Disp_sel,
  output logic       Blink,
  output logic       Buzzer,
  output logic [1:0] Snooze_cnt
);

  typedef enum logic [2:0] {
    S_RUN       = 3'd0,
    S_SET_TIME  = 3'd1,
    S_SET_ALARM = 3'd2,
    S_RINGING   = 3'd3,
    S_SNOOZE    = 3'd4
  } state_t;

  localparam logic [1:0] F_NONE = 2'b00;
  localparam logic [1:0] F_DAY  = 2'b01;
  localparam logic [1:0] F_HOUR = 2'b10;
  localparam logic [1:0] F_MIN  = 2'b11;

  // Wide enough for any sensible seconds limit; saturates rather than wraps.
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_S);
  localparam logic [CNT_W-1:0] RING_C    = CNT_W'(RING_S);
  localparam logic [CNT_W-1:0] SNOOZE_C  = CNT_W'(SNOOZE_S);
  localparam logic [1:0]       MAX_SNZ_C = 2'(MAX_SNOOZE);

  // Seconds counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Field selection order while setting: day -> hour -> minute -> day.
  function automatic logic [1:0] next_field(input logic [1:0] f);
    case (f)
      F_DAY:   return F_HOUR;
      F_HOUR:  return F_MIN;
      default: return F_DAY;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       field_q, field_d;
  logic [1:0]       snz_q, snz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_tick;
  logic             btn_acc;

  logic             inc_day_q, inc_day_d;
  logic             inc_hr_q, inc_hr_d;
  logic             inc_min_q, inc_min_d;
  logic             tgt_q, disp_q, blink_q, buzz_q;

  // Previous-sample registers for edge detection; preset high at reset so a
  // level already asserted during reset is not mistaken for a press.
  logic             mode_prev_q, next_prev_q, inc_prev_q, snz_prev_q, match_prev_q;

  logic             mode_e, next_e, inc_e, snz_e, match_e;

  assign mode_e  = Mode_btn    & ~mode_prev_q;
  assign next_e  = Next_btn    & ~next_prev_q;
  assign inc_e   = Inc_btn     & ~inc_prev_q;
  assign snz_e   = Snooze_btn  & ~snz_prev_q;
  assign match_e = Alarm_match & ~match_prev_q;

  // Next-state, strobe and seconds-counter decisions for the mode sequencer.
  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    snz_d     = snz_q;
    inc_day_d = 1'b0;
    inc_hr_d  = 1'b0;
    inc_min_d = 1'b0;
    btn_acc   = 1'b0;
    cnt_tick  = Tick_1Hz ? sat_inc(cnt_q) : cnt_q;

    case (state_q)
      S_RUN: begin
        if (match_e && Alarm_en) begin
          state_d = S_RINGING;
        end else if (mode_e) begin
          state_d = S_SET_TIME;
          field_d = F_DAY;
        end
      end

      S_SET_TIME, S_SET_ALARM: begin
        // One button action per cycle: Mode beats Next beats Inc.
        if (mode_e) begin
          btn_acc = 1'b1;
          if (state_q == S_SET_TIME) begin
            state_d = S_SET_ALARM;
            field_d = F_DAY;
          end else begin
            state_d = S_RUN;
          end
        end else if (next_e) begin
          btn_acc = 1'b1;
          field_d = next_field(field_q);
        end else if (inc_e) begin
          btn_acc = 1'b1;
          case (field_q)
            F_DAY:   inc_day_d = 1'b1;
            F_HOUR:  inc_hr_d  = 1'b1;
            F_MIN:   inc_min_d = 1'b1;
            default: ;
          endcase
        end else if (Tick_1Hz && (cnt_tick == TIMEOUT_C)) begin
          state_d = S_RUN;
        end
      end

      S_RINGING: begin
        if (!Alarm_en || mode_e || inc_e) begin
          state_d = S_RUN;
        end else if (snz_e && (snz_q < MAX_SNZ_C)) begin
          state_d = S_SNOOZE;
          snz_d   = snz_q + 2'd1;
        end else if (Tick_1Hz && (cnt_tick == RING_C)) begin
          state_d = S_RUN;
        end
      end

      S_SNOOZE: begin
        if (!Alarm_en || mode_e) begin
          state_d = S_RUN;
        end else if (Tick_1Hz && (cnt_tick == SNOOZE_C)) begin
          state_d = S_RINGING;
        end
      end

      default: state_d = S_RUN;
    endcase

    // Returning to RUN always forgets the field and the snooze history.
    if (state_d == S_RUN) begin
      field_d = F_NONE;
      snz_d   = 2'd0;
    end

    // A state change or an accepted press restarts the seconds count; a tick
    // in the same cycle is absorbed by the clear.
    cnt_d = ((state_d != state_q) || btn_acc) ? '0 : cnt_tick;
  end

  // State, counters, edge-detect history and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_RUN;
      field_q      <= F_NONE;
      snz_q        <= 2'd0;
      cnt_q        <= '0;
      inc_day_q    <= 1'b0;
      inc_hr_q     <= 1'b0;
      inc_min_q    <= 1'b0;
      tgt_q        <= 1'b0;
      disp_q       <= 1'b0;
      blink_q      <= 1'b0;
      buzz_q       <= 1'b0;
      mode_prev_q  <= 1'b1;
      next_prev_q  <= 1'b1;
      inc_prev_q   <= 1'b1;
      snz_prev_q   <= 1'b1;
      match_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      field_q      <= field_d;
      snz_q        <= snz_d;
      cnt_q        <= cnt_d;
      inc_day_q    <= inc_day_d;
      inc_hr_q     <= inc_hr_d;
      inc_min_q    <= inc_min_d;
      tgt_q        <= (state_d == S_SET_ALARM);
      disp_q       <= (state_d == S_SET_ALARM);
      blink_q      <= (field_d != F_NONE);
      buzz_q       <= (state_d == S_RINGING);
      mode_prev_q  <= Mode_btn;
      next_prev_q  <= Next_btn;
      inc_prev_q   <= Inc_btn;
      snz_prev_q   <= Snooze_btn;
      match_prev_q <= Alarm_match;
    end
  end

  assign Mode       = state_q;
  assign Field      = field_q;
  assign Inc_D      = inc_day_q;
  assign Inc_H      = inc_hr_q;
  assign Inc_M      = inc_min_q;
  assign Tgt_alarm  = tgt_q;
  assign Disp_sel   = disp_q;
  assign Blink      = blink_q;
  assign Buzzer     = buzz_q;
  assign Snooze_cnt = snz_q;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed testbench for clock_mode_controller with hand-computed expectations.
module tb_clock_mode_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Tick_1Hz = 1'b0;
  logic       Mode_btn = 1'b0;
  logic       Next_btn = 1'b0;
  logic       Inc_btn = 1'b0;
  logic       Snooze_btn = 1'b0;
  logic       Alarm_en = 1'b0;
  logic       Alarm_match = 1'b0;
  logic [2:0] Mode;
  logic [1:0] Field;
  logic       Inc_D, Inc_H, Inc_M, Tgt_alarm, Disp_sel, Blink, Buzzer;
  logic [1:0] Snooze_cnt;

  int n_total = 0;
  int n_pass  = 0;

  clock_mode_controller dut (
    .Clk(Clk), .Reset(Reset), .Tick_1Hz(Tick_1Hz),
    .Mode_btn(Mode_btn), .Next_btn(Next_btn), .Inc_btn(Inc_btn),
    .Snooze_btn(Snooze_btn), .Alarm_en(Alarm_en), .Alarm_match(Alarm_match),
    .Mode(Mode), .Field(Field), .Inc_D(Inc_D), .Inc_H(Inc_H), .Inc_M(Inc_M),
    .Tgt_alarm(Tgt_alarm), .Disp_sel(Disp_sel), .Blink(Blink), .Buzzer(Buzzer),
    .Snooze_cnt(Snooze_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // which = {Mode, Next, Inc, Snooze}; buttons stay high until rel().
  task automatic press(input logic [3:0] which);
    {Mode_btn, Next_btn, Inc_btn, Snooze_btn} = which;
    cyc();
  endtask

  task automatic rel();
    {Mode_btn, Next_btn, Inc_btn, Snooze_btn} = 4'b0000;
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      Tick_1Hz = 1'b1;
      cyc();
      Tick_1Hz = 1'b0;
      cyc();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Mode_btn = 1'b1;
    cyc(); cyc();
    Reset = 1'b0;
    cyc();
    n_total++; if (Mode !== 3'd0) $display("FAIL rst_mode: got %0d want 0", Mode); else n_pass++;
    n_total++; if (Field !== 2'b00) $display("FAIL rst_field: got %0d want 0", Field); else n_pass++;
    n_total++; if ({Inc_D, Inc_H, Inc_M, Tgt_alarm, Disp_sel, Blink, Buzzer} !== 7'b0)
      $display("FAIL rst_flags: got %b want 0000000", {Inc_D, Inc_H, Inc_M, Tgt_alarm, Disp_sel, Blink, Buzzer});
    else n_pass++;
    n_total++; if (Snooze_cnt !== 2'd0) $display("FAIL rst_snz: got %0d want 0", Snooze_cnt); else n_pass++;
    cyc(); cyc();
    n_total++; if (Mode !== 3'd0) $display("FAIL rst_held_btn: got %0d want 0", Mode); else n_pass++;
    Mode_btn = 1'b0; cyc();
    Mode_btn = 1'b1; cyc();
    n_total++; if (Mode !== 3'd1) $display("FAIL rst_new_edge_mode: got %0d want 1", Mode); else n_pass++;
    n_total++; if (Field !== 2'b01 || Blink !== 1'b1)
      $display("FAIL rst_new_edge_field: got field=%0d blink=%0d want 1/1", Field, Blink);
    else n_pass++;
    Mode_btn = 1'b0; cyc();
  endtask

  // Starts in SET_TIME with Field=01.
  task automatic test_set_time();
    press(4'b0100);
    n_total++; if (Field !== 2'b10) $display("FAIL st_next1: got %0d want 2", Field); else n_pass++;
    rel();
    press(4'b0100);
    n_total++; if (Field !== 2'b11) $display("FAIL st_next2: got %0d want 3", Field); else n_pass++;
    rel();
    press(4'b0010);
    n_total++; if ({Inc_D, Inc_H, Inc_M, Tgt_alarm} !== 4'b0010)
      $display("FAIL st_inc_min: got DHM/T=%b want 0010", {Inc_D, Inc_H, Inc_M, Tgt_alarm});
    else n_pass++;
    cyc();
    n_total++; if (Inc_M !== 1'b0) $display("FAIL st_inc_no_repeat: got %0d want 0", Inc_M); else n_pass++;
    rel();
    press(4'b0100);
    n_total++; if (Field !== 2'b01) $display("FAIL st_next_wrap: got %0d want 1", Field); else n_pass++;
    rel();
  endtask

  // Starts in SET_TIME with Field=01.
  task automatic test_set_alarm();
    press(4'b1000);
    n_total++; if (Mode !== 3'd2 || Field !== 2'b01 || Disp_sel !== 1'b1)
      $display("FAIL sa_enter: got mode=%0d field=%0d disp=%0d want 2/1/1", Mode, Field, Disp_sel);
    else n_pass++;
    rel();
    press(4'b0010);
    n_total++; if ({Inc_D, Inc_H, Inc_M, Tgt_alarm} !== 4'b1001)
      $display("FAIL sa_inc_day: got DHM/T=%b want 1001", {Inc_D, Inc_H, Inc_M, Tgt_alarm});
    else n_pass++;
    rel();
    ticks(9);
    n_total++; if (Mode !== 3'd2) $display("FAIL sa_before_timeout: got %0d want 2", Mode); else n_pass++;
    Tick_1Hz = 1'b1; cyc();
    n_total++; if (Mode !== 3'd0 || Field !== 2'b00 || Disp_sel !== 1'b0 || Blink !== 1'b0)
      $display("FAIL sa_timeout: got mode=%0d field=%0d disp=%0d blink=%0d want 0/0/0/0", Mode, Field, Disp_sel, Blink);
    else n_pass++;
    Tick_1Hz = 1'b0; cyc();
  endtask

  task automatic test_priority();
    press(4'b1000); rel();
    ticks(9);
    Tick_1Hz = 1'b1; Next_btn = 1'b1; cyc();
    n_total++; if (Mode !== 3'd1 || Field !== 2'b10)
      $display("FAIL pr_tick_with_btn: got mode=%0d field=%0d want 1/2", Mode, Field);
    else n_pass++;
    Tick_1Hz = 1'b0; rel();
    ticks(9);
    n_total++; if (Mode !== 3'd1) $display("FAIL pr_counter_cleared: got %0d want 1", Mode); else n_pass++;
    press(4'b0110);
    n_total++; if (Field !== 2'b11 || {Inc_D, Inc_H, Inc_M} !== 3'b000)
      $display("FAIL pr_next_over_inc: got field=%0d DHM=%b want 3/000", Field, {Inc_D, Inc_H, Inc_M});
    else n_pass++;
    rel();
    press(4'b1000); rel();
    press(4'b1000);
    n_total++; if (Mode !== 3'd0 || Field !== 2'b00)
      $display("FAIL pr_alarm_to_run: got mode=%0d field=%0d want 0/0", Mode, Field);
    else n_pass++;
    rel();
  endtask

  task automatic test_ring();
    Alarm_en = 1'b1;
    press(4'b1000); rel();
    Alarm_match = 1'b1; cyc();
    n_total++; if (Mode !== 3'd1 || Buzzer !== 1'b0)
      $display("FAIL rg_ignored_in_set: got mode=%0d buzz=%0d want 1/0", Mode, Buzzer);
    else n_pass++;
    press(4'b1000); rel();
    press(4'b1000); rel();
    n_total++; if (Mode !== 3'd0) $display("FAIL rg_no_late_edge: got %0d want 0", Mode); else n_pass++;
    Alarm_match = 1'b0; cyc();
    Alarm_match = 1'b1;
    press(4'b1000);
    n_total++; if (Mode !== 3'd3 || Buzzer !== 1'b1 || Field !== 2'b00)
      $display("FAIL rg_alarm_over_mode: got mode=%0d buzz=%0d field=%0d want 3/1/0", Mode, Buzzer, Field);
    else n_pass++;
    rel();
    ticks(59);
    n_total++; if (Mode !== 3'd3) $display("FAIL rg_before_auto: got %0d want 3", Mode); else n_pass++;
    Tick_1Hz = 1'b1; cyc();
    n_total++; if (Mode !== 3'd0 || Buzzer !== 1'b0)
      $display("FAIL rg_auto_dismiss: got mode=%0d buzz=%0d want 0/0", Mode, Buzzer);
    else n_pass++;
    Tick_1Hz = 1'b0; Alarm_match = 1'b0; cyc();
  endtask

  task automatic test_snooze();
    Alarm_match = 1'b1; cyc();
    n_total++; if (Mode !== 3'd3 || Snooze_cnt !== 2'd0)
      $display("FAIL sn_start: got mode=%0d snz=%0d want 3/0", Mode, Snooze_cnt);
    else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      press(4'b0001);
      n_total++; if (Mode !== 3'd4 || Snooze_cnt !== 2'(k) || Buzzer !== 1'b0)
        $display("FAIL sn_enter%0d: got mode=%0d snz=%0d buzz=%0d want 4/%0d/0", k, Mode, Snooze_cnt, Buzzer, k);
      else n_pass++;
      rel();
      ticks(299);
      n_total++; if (Mode !== 3'd4) $display("FAIL sn_hold%0d: got %0d want 4", k, Mode); else n_pass++;
      Tick_1Hz = 1'b1; cyc();
      n_total++; if (Mode !== 3'd3 || Buzzer !== 1'b1)
        $display("FAIL sn_resume%0d: got mode=%0d buzz=%0d want 3/1", k, Mode, Buzzer);
      else n_pass++;
      Tick_1Hz = 1'b0; cyc();
    end
    press(4'b0001);
    n_total++; if (Mode !== 3'd3 || Snooze_cnt !== 2'd3)
      $display("FAIL sn_limit: got mode=%0d snz=%0d want 3/3", Mode, Snooze_cnt);
    else n_pass++;
    rel();
    press(4'b0010);
    n_total++; if (Mode !== 3'd0 || Snooze_cnt !== 2'd0 || {Inc_D, Inc_H, Inc_M} !== 3'b000)
      $display("FAIL sn_inc_dismiss: got mode=%0d snz=%0d DHM=%b want 0/0/000", Mode, Snooze_cnt, {Inc_D, Inc_H, Inc_M});
    else n_pass++;
    rel();
    Alarm_match = 1'b0; cyc();
  endtask

  task automatic test_reset_mid();
    Alarm_match = 1'b1; cyc();
    press(4'b0001);
    n_total++; if (Mode !== 3'd4) $display("FAIL rm_in_snooze: got %0d want 4", Mode); else n_pass++;
    rel();
    Reset = 1'b1; cyc();
    n_total++; if (Mode !== 3'd0 || Snooze_cnt !== 2'd0 || Buzzer !== 1'b0)
      $display("FAIL rm_reset: got mode=%0d snz=%0d buzz=%0d want 0/0/0", Mode, Snooze_cnt, Buzzer);
    else n_pass++;
    Reset = 1'b0; Alarm_match = 1'b0; cyc();
  endtask

  task automatic test_alarm_en();
    Alarm_match = 1'b1; cyc();
    n_total++; if (Mode !== 3'd3) $display("FAIL ae_ring: got %0d want 3", Mode); else n_pass++;
    Alarm_en = 1'b0; cyc();
    n_total++; if (Mode !== 3'd0) $display("FAIL ae_disarm: got %0d want 0", Mode); else n_pass++;
    Alarm_match = 1'b0; cyc();
    Alarm_match = 1'b1; cyc();
    n_total++; if (Mode !== 3'd0 || Buzzer !== 1'b0)
      $display("FAIL ae_disabled_match: got mode=%0d buzz=%0d want 0/0", Mode, Buzzer);
    else n_pass++;
    Alarm_match = 1'b0; cyc();
  endtask

  initial begin
    test_reset();
    test_set_time();
    test_set_alarm();
    test_priority();
    test_ring();
    test_snooze();
    test_reset_mid();
    test_alarm_en();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
